dbg_bus_bridge: RTL
===================

DBG_BUS_BRIDGE -- requirements
Module: dbg_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_BITS, default 8, giving the width of the bus-wait timeout counter; timeout fires after 2^TIMEOUT_BITS-1 wait cycles.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rx_data (input, 8) and rx_valid (input, 1): command byte stream from the host (UART receive side).
REQ-005 SHALL have port rx_ready, output, 1: bridge accepts rx_data on the cycle rx_valid && rx_ready.
REQ-006 SHALL have ports tx_data (output, 8) and tx_valid (output, 1): response byte stream to the host.
REQ-007 SHALL have port tx_ready, input, 1: the response byte is consumed on the cycle tx_valid && tx_ready.
REQ-008 SHALL have port stb, output, 1: one-cycle bus request strobe toward the interconnect.
REQ-009 SHALL have port ack, input, 1: one-cycle bus completion pulse.
REQ-010 SHALL have ports rw (output, 1, 1=write), addr (output, 32), dtw (output, 32, write data).
REQ-011 SHALL have port dtr, input, 32: read data, valid in the cycle ack is high.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, ADDR, DATA, BUS, WAIT, RESP.
REQ-014 IDLE: rx_ready=1; opcode byte 0x52 ('R') -> ADDR with rw=0; 0x57 ('W') -> ADDR with rw=1; any other byte -> RESP sending the single byte 0x45 ('E').
REQ-015 ADDR: rx_ready=1; accepts 4 bytes big-endian (first byte -> addr[31:24]); after the 4th, 'W' -> DATA, 'R' -> BUS.
REQ-016 DATA: rx_ready=1; accepts 4 bytes big-endian into dtw; after the 4th -> BUS.
REQ-017 rx_ready SHALL be 0 in BUS, WAIT, RESP; input bytes are never dropped, only stalled.
REQ-018 BUS: stb=1 for exactly one cycle with addr/rw/dtw stable; next state WAIT; if ack is high in that same cycle, the transaction is complete and WAIT is skipped (-> RESP).
REQ-019 addr, rw, dtw SHALL remain stable from BUS until the transaction completes or times out.
REQ-020 WAIT: stb=0; timeout counter increments each cycle; ack=1 -> RESP with success; counter reaching 2^TIMEOUT_BITS-1 without ack -> RESP sending the single byte 0x54 ('T').
REQ-021 On read success, dtr SHALL be captured in the ack cycle; response = 0x4B ('K') then dtr[31:24], [23:16], [15:8], [7:0] (5 bytes).
REQ-022 On write success, response = single byte 0x4B.
REQ-023 RESP: tx_valid=1 with tx_data stable until tx_ready; next byte presented the cycle after each handshake; after the last handshake -> IDLE; tx_valid=0 outside RESP.
REQ-024 ack received in IDLE/ADDR/DATA/RESP (late ack after a timeout) SHALL be ignored.
REQ-025 Byte counter and timeout counter SHALL clear on every entry to ADDR, DATA, WAIT and RESP.
REQ-026 Throughput: a read completes in at least 5 rx cycles + 1 BUS + ack latency + 5 tx handshakes; no idle bubble inserted between accepted rx bytes.

Reset
REQ-027 While reset is high: state=IDLE, stb=0, tx_valid=0, rx_ready=0, busy=0, rw=0, addr=0, dtw=0, tx_data=0, all counters 0.
REQ-028 Reset asserted mid-transaction (any state) SHALL abort immediately with no further stb and no response byte; first cycle after release: rx_ready=1.

Verification
REQ-029 Read: rx 52 00 00 01 00, ack 3 cycles after stb with dtr=DEADBEEF -> one stb with addr=00000100 rw=0; tx 4B DE AD BE EF.
REQ-030 Write: rx 57 80 00 00 04 12 34 56 78, ack same cycle as stb -> stb with addr=80000004 rw=1 dtw=12345678; tx 4B only.
REQ-031 Timeout: TIMEOUT_BITS=4, read with ack never asserted -> tx 54 after 15 WAIT cycles; ack pulsed later in IDLE ignored, busy=0.
REQ-032 Bad opcode: rx 00 -> tx 45, no stb, return to IDLE; following valid read command processed normally.
REQ-033 Backpressure: tx_ready low 10 cycles during read response -> tx_data held at 4B until accepted, all 5 bytes in order; rx_valid held high during RESP sees rx_ready=0.
REQ-034 Reset in WAIT: assert reset 2 cycles after stb -> stb=0, tx_valid=0, busy=0 at once; no response byte after release.

Source files
------------

// File: rtl/dbg_bus_bridge_if.sv
// Signal bundle between the debug bridge, its host byte streams and the bus interconnect.
// The master view belongs to the bridge; the slave view to the host/interconnect side.
interface dbg_bus_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        stb;
    logic        ack;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic [31:0] dtr;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, ack, dtr,
        output rx_ready, tx_data, tx_valid, stb, rw, addr, dtw, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, ack, dtr,
        input  rx_ready, tx_data, tx_valid, stb, rw, addr, dtw, busy
    );
endinterface

// File: rtl/dbg_bus_bridge.sv
// Host byte-command to single-transfer bus bridge: parses R/W commands, issues one bus
// strobe, waits for ack with a timeout and streams a status/data response back.
module dbg_bus_bridge #(
    parameter int unsigned TIMEOUT_BITS = 8
) (
    input logic              clk,
    input logic              reset,
    dbg_bus_bridge_if.master dbg
);
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAddr = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StBus  = 3'd3;
    localparam logic [2:0] StWait = 3'd4;
    localparam logic [2:0] StResp = 3'd5;

    localparam logic [TIMEOUT_BITS-1:0] TmoMax = '1;
    localparam logic [TIMEOUT_BITS-1:0] TmoOne = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

    logic [2:0]              state_q, state_d;
    logic [2:0]              byte_cnt_q, byte_cnt_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    rw_q, rw_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             dtw_q, dtw_d;
    logic [39:0]             rsp_q, rsp_d;
    logic [2:0]              rsp_len_q, rsp_len_d;

    logic        rx_fire, tx_fire;
    logic [39:0] ok_rsp;
    logic [2:0]  ok_len;

    assign rx_fire = dbg.rx_valid && dbg.rx_ready;
    assign tx_fire = dbg.tx_valid && dbg.tx_ready;
    // Read success returns 'K' plus the data captured in the ack cycle; write returns 'K' only.
    assign ok_rsp  = rw_q ? {8'h4B, 32'h0} : {8'h4B, dbg.dtr};
    assign ok_len  = rw_q ? 3'd1 : 3'd5;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        dtw_d      = dtw_q;
        rsp_d      = rsp_q;
        rsp_len_d  = rsp_len_q;
        case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    if (dbg.rx_data == 8'h52) begin
                        rw_d    = 1'b0;
                        state_d = StAddr;
                    end else if (dbg.rx_data == 8'h57) begin
                        rw_d    = 1'b1;
                        state_d = StAddr;
                    end else begin
                        rsp_d     = {8'h45, 32'h0};
                        rsp_len_d = 3'd1;
                        state_d   = StResp;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d     = {addr_q[23:0], dbg.rx_data};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd3) begin
                        byte_cnt_d = '0;
                        tmo_d      = '0;
                        state_d    = rw_q ? StData : StBus;
                    end
                end
            end
            StData: begin
                if (rx_fire) begin
                    dtw_d      = {dtw_q[23:0], dbg.rx_data};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd3) begin
                        byte_cnt_d = '0;
                        tmo_d      = '0;
                        state_d    = StBus;
                    end
                end
            end
            StBus: begin
                byte_cnt_d = '0;
                tmo_d      = '0;
                if (dbg.ack) begin
                    rsp_d     = ok_rsp;
                    rsp_len_d = ok_len;
                    state_d   = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                tmo_d = tmo_q + TmoOne;
                if (dbg.ack) begin
                    tmo_d     = '0;
                    rsp_d     = ok_rsp;
                    rsp_len_d = ok_len;
                    state_d   = StResp;
                end else if (tmo_d == TmoMax) begin
                    tmo_d     = '0;
                    rsp_d     = {8'h54, 32'h0};
                    rsp_len_d = 3'd1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (tx_fire) begin
                    if (byte_cnt_q == rsp_len_q - 3'd1) begin
                        byte_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        rsp_d      = {rsp_q[31:0], 8'h00};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            dtw_q      <= '0;
            rsp_q      <= '0;
            rsp_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            dtw_q      <= dtw_d;
            rsp_q      <= rsp_d;
            rsp_len_q  <= rsp_len_d;
        end
    end

    // rx_ready is gated by reset so the host sees no acceptance while reset is held.
    assign dbg.rx_ready = !reset &&
                          (state_q == StIdle || state_q == StAddr || state_q == StData);
    assign dbg.tx_valid = (state_q == StResp);
    assign dbg.tx_data  = rsp_q[39:32];
    assign dbg.stb      = (state_q == StBus);
    assign dbg.busy     = (state_q != StIdle);
    assign dbg.rw       = rw_q;
    assign dbg.addr     = addr_q;
    assign dbg.dtw      = dtw_q;
endmodule
